// File: rtl/md_stall_ctrl_pkg.sv
// Shared stall-bus codes, FSM state encoding and the stall merge helper
// for the pipeline sequencing controller.
package md_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Prefix masks: OR of any subset equals the deepest active code.
    localparam stall_bus_t NO_STALL = 6'b000000;
    localparam stall_bus_t LOAD_USE = 6'b000111;
    localparam stall_bus_t MD_HOLD  = 6'b001111;
    localparam stall_bus_t MEM_WAIT = 6'b011111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic stall_bus_t stall_merge(input logic id_req,
                                               input logic md_req,
                                               input logic mem_req);
        stall_bus_t s;
        s = NO_STALL;
        if (id_req)  s = s | LOAD_USE;
        if (md_req)  s = s | MD_HOLD;
        if (mem_req) s = s | MEM_WAIT;
        return s;
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable latency up-counter: clears on load, counts while enabled,
// saturates at all-ones and flags when the count reaches the loaded terminal.
module md_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            term_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            term_q <= term;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term_q);

endmodule

// File: rtl/md_stall_ctrl.sv
// Merges ID/MEM stall requests with the mult/div hold into the per-stage
// stall bus, and sequences the shared multi-cycle mult/div unit.
module md_stall_ctrl
    import md_stall_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       stallreq_mem,
    input  logic       md_req,
    input  logic       md_is_div,
    output logic       md_start,
    output logic       md_done,
    output logic       md_busy,
    output logic [5:0] stall
);

    generate
        if (DIV_LAT >= (2 ** CNT_W) || MUL_LAT >= (2 ** CNT_W)) begin : g_bad_cnt_w
            $error("md_stall_ctrl: CNT_W too narrow for DIV_LAT/MUL_LAT");
        end
        if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
            $error("md_stall_ctrl: latencies must be at least 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_TERM = CNT_W'(DIV_LAT - 1);

    md_state_e        state;
    logic             mem_wait;
    logic             md_hold;
    logic             issue;
    logic             cnt_tc;
    logic [CNT_W-1:0] term;

    // Only MEM_WAIT can hold EX/MEM from outside; our own MD_HOLD must not
    // block the issue it exists to protect.
    assign mem_wait = stallreq_mem;
    assign issue    = (state == MD_IDLE) && md_req && !mem_wait;
    assign term     = md_is_div ? DIV_TERM : MUL_TERM;
    assign md_hold  = (state == MD_BUSY) || ((state == MD_IDLE) && md_req);
    assign md_busy  = (state != MD_IDLE);

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (issue),
        .inc  (state == MD_BUSY),
        .term (term),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MD_IDLE;
            md_start <= 1'b0;
            md_done  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_done  <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (issue) begin
                        md_start <= 1'b1;
                        state    <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // md_req dropping here is illegal; the count runs to completion.
                    if (cnt_tc) begin
                        md_done <= 1'b1;
                        state   <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!mem_wait) state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Inputs may be high during reset; the bus must still read all-go.
    always_comb begin
        stall = NO_STALL;
        if (rst) stall = stall_merge(stallreq_id, md_hold, stallreq_mem);
    end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed self-checking bench for md_stall_ctrl: stall merge, mult/div
// sequencing, MEM hold in DONE and IDLE, and asynchronous reset mid-divide.
module tb_md_stall_ctrl;

    logic       clk;
    logic       rst;
    logic       stallreq_id;
    logic       stallreq_mem;
    logic       md_req;
    logic       md_is_div;
    logic       md_start;
    logic       md_done;
    logic       md_busy;
    logic [5:0] stall;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LU   = 6'b000111;
    localparam logic [5:0] S_MD   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    md_stall_ctrl #(
        .MUL_LAT (2),
        .DIV_LAT (33),
        .CNT_W   (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .md_req       (md_req),
        .md_is_div    (md_is_div),
        .md_start     (md_start),
        .md_done      (md_done),
        .md_busy      (md_busy),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // md_req must stay high for as long as the unit is occupied.
    always @(negedge clk) begin
        if (rst && md_busy && !md_req) $error("md_req dropped while unit occupied");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int c, input logic [5:0] e_stall,
                           input logic e_start, input logic e_done, input logic e_busy);
        chk($sformatf("%s c%0d stall", nm, c), {2'b0, stall}, {2'b0, e_stall});
        chk($sformatf("%s c%0d start", nm, c), {7'b0, md_start}, {7'b0, e_start});
        chk($sformatf("%s c%0d done", nm, c), {7'b0, md_done}, {7'b0, e_done});
        chk($sformatf("%s c%0d busy", nm, c), {7'b0, md_busy}, {7'b0, e_busy});
    endtask

    // One isolated op: req at c=0, start at 1, done at lat+1, IDLE at lat+2.
    task automatic run_single(input string nm, input logic div);
        int lat;
        lat = div ? 33 : 2;
        md_req    = 1'b1;
        md_is_div = div;
        #2 chk_all(nm, 0, S_MD, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= lat + 2; c++) begin
            tick();
            if (c == lat + 2) md_req = 1'b0;
            #2 chk_all(nm, c, (c <= lat) ? S_MD : S_NONE, c == 1, c == lat + 1, c <= lat + 1);
        end
    endtask

    initial begin
        rst          = 1'b0;
        stallreq_id  = 1'b1;
        stallreq_mem = 1'b1;
        md_req       = 1'b1;
        md_is_div    = 1'b0;
        repeat (2) @(posedge clk);
        #3 chk_all("reset", 0, S_NONE, 1'b0, 1'b0, 1'b0);
        stallreq_id  = 1'b0;
        stallreq_mem = 1'b0;
        md_req       = 1'b0;
        tick();
        rst = 1'b1;

        // Load-use alone
        tick();
        stallreq_id = 1'b1;
        #2 chk_all("lu", 0, S_LU, 1'b0, 1'b0, 1'b0);
        tick();
        stallreq_id = 1'b0;
        #2 chk_all("lu", 1, S_NONE, 1'b0, 1'b0, 1'b0);

        // Single divide
        tick();
        run_single("div", 1'b1);

        // Back-to-back multiplies: starts at 1 and 5, dones at 3 and 7
        tick();
        md_req    = 1'b1;
        md_is_div = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            logic [5:0] es;
            if (c > 0) tick();
            if (c == 8) md_req = 1'b0;
            es = (c == 3 || c == 7 || c == 8) ? S_NONE : S_MD;
            #2 chk_all("b2b", c, es, c == 1 || c == 5, c == 3 || c == 7,
                       (c >= 1 && c <= 3) || (c >= 5 && c <= 7));
        end

        // MEM wait while in DONE for three cycles
        tick();
        md_req    = 1'b1;
        md_is_div = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            logic [5:0] es;
            if (c > 0) tick();
            stallreq_mem = (c >= 3 && c <= 5);
            if (c == 7) md_req = 1'b0;
            es = (c <= 2) ? S_MD : (c <= 5) ? S_MEM : S_NONE;
            #2 chk_all("dmem", c, es, c == 1, c == 3, c >= 1 && c <= 6);
        end

        // Load-use concurrent with BUSY, still high after DONE
        tick();
        md_req    = 1'b1;
        md_is_div = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            logic [5:0] es;
            if (c > 0) tick();
            stallreq_id = (c >= 1 && c <= 4);
            if (c == 4) md_req = 1'b0;
            es = (c <= 2) ? S_MD : (c <= 4) ? S_LU : S_NONE;
            #2 chk_all("lubusy", c, es, c == 1, c == 3, c >= 1 && c <= 3);
        end

        // MEM wait in IDLE blocks issue until it clears
        tick();
        md_req       = 1'b1;
        md_is_div    = 1'b0;
        stallreq_mem = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            logic [5:0] es;
            if (c > 0) tick();
            stallreq_mem = (c <= 1);
            if (c == 6) md_req = 1'b0;
            es = (c <= 1) ? S_MEM : (c <= 4) ? S_MD : S_NONE;
            #2 chk_all("imem", c, es, c == 3, c == 5, c >= 3 && c <= 5);
        end

        // Async reset at cnt=10 of a divide, then a fresh full-latency divide
        tick();
        md_req    = 1'b1;
        md_is_div = 1'b1;
        repeat (11) tick();
        #2 chk_all("prerst", 11, S_MD, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1 chk_all("midrst", 11, S_NONE, 1'b0, 1'b0, 1'b0);
        md_req = 1'b0;
        tick();
        #2 chk_all("inrst", 12, S_NONE, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        run_single("redo", 1'b1);

        tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
